mode_counter: RTL and testbench
===============================

# mode_counter

Parametrised up/down counter: next-generation replacement for the fixed 4-bit up-counter in the top-level user module. Adds configurable width and modulus, direction control, wrap/saturate mode, synchronous load and clear, a clock-enable prescaler, and registered terminal/overflow flags. The top level instantiates it with count on `uo_out` and controls on `ui_in`. It runs on the system clock rather than a pin-driven clock.

## Interface

**Parameters**
- `WIDTH`, 8: counter width in bits, 1 to 16.
- `MAX`, 2**WIDTH-1: inclusive upper count limit (modulus MAX+1). Required: 1 ≤ MAX ≤ 2**WIDTH-1.
- `DIV`, 1: prescale factor. The counter steps once per DIV enabled cycles. DIV ≥ 1.

**Ports**
- `clk` input, 1: system clock, rising-edge.
- `rst_n` input, 1: reset, asynchronous assert, active-low.
- `en` input, 1: count enable. It gates the prescaler.
- `dir` input, 1: direction. 1 = up, 0 = down.
- `sat` input, 1: boundary mode. 0 = wrap, 1 = saturate.
- `clr` input, 1: synchronous clear.
- `load` input, 1: synchronous load.
- `load_val` input, WIDTH: value for load.
- `count` output, WIDTH: current count, registered.
- `zero` output, 1: `count == 0`, combinational from the count register.
- `tc` output, 1: registered one-cycle pulse when a step crosses or hits the boundary.
- `ovf` output, 1: sticky flag, set on any wrap or saturation event.

## Operation

**Internal state**
- `count` register, WIDTH bits.
- Prescaler `div_cnt`, ceil(log2(DIV)) bits, min 1. Absent when DIV=1.
- `tc` register.
- `ovf` register.

**Step strobe**
- `step = en && (div_cnt == DIV-1)`.
- On `en`, `div_cnt` increments, returning to 0 after DIV-1.
- `div_cnt` holds while `en` = 0.

**Per-edge priority (highest first)**
1. `clr`: count←0, div_cnt←0, tc←0, ovf←0.
2. `load`: count←min(load_val, MAX), div_cnt←0, tc←0. ovf unchanged.
3. `step`: count updated per the boundary rules below.
4. Otherwise: count holds, tc←0.

**Boundary rules on step**
- Up, count < MAX: count+1, tc←0.
- Up, count == MAX, sat=0: count←0, tc←1, ovf←1.
- Up, count == MAX, sat=1: count holds MAX, tc←1, ovf←1.
- Down, count > 0: count−1, tc←0.
- Down, count == 0, sat=0: count←MAX, tc←1, ovf←1.
- Down, count == 0, sat=1: count holds 0, tc←1, ovf←1.
- Up, count > MAX (unreachable, defensive): count←0 in wrap mode, MAX in sat mode.

**Mode changes**
- `dir` and `sat` may change on any cycle. They take effect on the next step.
- They do not reset the prescaler.

**Arithmetic**
- All arithmetic is unsigned, modulo MAX+1. No intermediate wider than WIDTH+1.

## Timing

**Reset**
- `rst_n` low asynchronously forces count=0, div_cnt=0, tc=0, ovf=0.
- Therefore `zero`=1 during reset.
- Deassertion is used synchronously by the surrounding logic. The block must behave correctly from the first rising edge after release.

**Latency**
- count, tc and ovf: one cycle from the sampled control edge.
- `zero`: follows count with no extra cycle.

**Pulse width and sequencing**
- `tc` is high for exactly one cycle per boundary event.
- Consecutive saturating steps produce one tc pulse per step.
- With DIV=N and `en` held high, the first step occurs on the Nth enabled edge after reset, clr or load.

**Mid-operation events**
- `clr` or `load` mid-prescale discards the partial prescale count.
- `load` and `clr` together: clr wins.
- `load` together with `step`: load wins and the step is lost.
- Reset mid-operation: all state is cleared immediately, with no clock required.

## Test plan

1. **Decade wrap.** WIDTH=4, MAX=9, DIV=1, en=1, dir=1, sat=0, 12 clocks from reset. Required: count 1..9, 0, 1, 2; tc high only on the cycle count=0 after 9; ovf=1 from then on.
2. **Down wrap and saturate.** Load 2, dir=0, sat=0, 3 steps. Required: 1, 0, 9 (MAX) with tc on the 9. Then sat=1, load 1, 3 steps. Required: 0, 0, 0 with tc pulsed on each of the last two steps.
3. **Prescaler.** DIV=3, en=1, 9 clocks. Required: count increments on clocks 3, 6, 9 only. Drop en for 2 clocks mid-period: the step is delayed by exactly 2 clocks.
4. **Priority.** Same edge load=1, load_val=5, clr=1: count=0, ovf cleared. Next edge load only with load_val=15 (MAX=9): count=9, clamped. Then load with a pending step: count equals the load value.
5. **Async reset.** Assert rst_n low between clock edges at count=7 with ovf=1. Required: count=0, zero=1, tc=0, ovf=0 immediately, without a clock edge. After release, counting resumes from 0 with a full DIV period.
6. **Full-width default.** WIDTH=8, MAX=255, up from 254. Required: 255, then 0 with a tc pulse. In sat mode: holds 255 and ovf sets.

Source files
------------

// File: rtl/mode_counter.sv
// Parametrised up/down counter with wrap/saturate boundary modes, a prescaler,
// synchronous clear/load and registered terminal-count and sticky overflow flags.
module mode_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 2**WIDTH-1,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             sat,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX);
  localparam logic [WIDTH-1:0] MAX_V = MAX_X[WIDTH-1:0];

  logic             step;
  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] ld_clamp;

  generate
    if (DIV == 1) begin : g_nodiv
      assign step = en;
    end else begin : g_div
      localparam int          DW   = $clog2(DIV);
      localparam logic [DW-1:0] LAST = DW'(DIV-1);
      logic [DW-1:0] div_cnt;

      // clr/load discard any partial prescale period
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           div_cnt <= '0;
        else if (clr || load) div_cnt <= '0;
        else if (en)          div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + DW'(1);
      end

      assign step = en && (div_cnt == LAST);
    end
  endgenerate

  // at_top also covers the unreachable count > MAX case
  assign at_top   = ({1'b0, count} >= MAX_X);
  assign at_bot   = (count == '0);
  assign ld_clamp = ({1'b0, load_val} > MAX_X) ? MAX_V : load_val;
  assign zero     = at_bot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= ld_clamp;
      tc    <= 1'b0;
    end else if (step) begin
      if (dir) begin
        if (at_top) begin
          count <= sat ? MAX_V : '0;
          tc    <= 1'b1;
          ovf   <= 1'b1;
        end else begin
          count <= count + WIDTH'(1);
          tc    <= 1'b0;
        end
      end else begin
        if (at_bot) begin
          count <= sat ? '0 : MAX_V;
          tc    <= 1'b1;
          ovf   <= 1'b1;
        end else begin
          count <= count - WIDTH'(1);
          tc    <= 1'b0;
        end
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench: three counter configurations share one stimulus stream and are
// compared every cycle against an integer reference model of the counting rules.
module tb_mode_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, dir = 1'b0, sat = 1'b0, clr = 1'b0, load = 1'b0;
  logic [7:0] load_val = '0;

  logic [3:0] cnt_a, cnt_b;
  logic [7:0] cnt_c;
  logic       zero_a, zero_b, zero_c, tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(4), .MAX(9), .DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .count(cnt_a), .zero(zero_a), .tc(tc_a), .ovf(ovf_a));
  mode_counter #(.WIDTH(4), .MAX(9), .DIV(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .count(cnt_b), .zero(zero_b), .tc(tc_b), .ovf(ovf_b));
  mode_counter dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .sat(sat), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_c), .zero(zero_c), .tc(tc_c), .ovf(ovf_c));

  logic [2:0][7:0] act_cnt;
  logic [2:0]      act_zero, act_tc, act_ovf;
  assign act_cnt  = {cnt_c, {4'b0, cnt_b}, {4'b0, cnt_a}};
  assign act_zero = {zero_c, zero_b, zero_a};
  assign act_tc   = {tc_c, tc_b, tc_a};
  assign act_ovf  = {ovf_c, ovf_b, ovf_a};

  typedef struct packed {
    logic [2:0][7:0] cnt;
    logic [2:0]      tc;
    logic [2:0]      ovf;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int failures = 0;

  // reference model: per configuration MAX, DIV, load width modulus
  int p_max[3] = '{9, 9, 255};
  int p_div[3] = '{1, 3, 1};
  int p_mod[3] = '{16, 16, 256};
  int m_cnt[3], m_dc[3], m_ovf[3], m_tc[3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_dc[i] = 0; m_ovf[i] = 0; m_tc[i] = 0;
    end
  endtask

  task automatic model(input bit r, e, d, s, c, l, input int lv);
    for (int i = 0; i < 3; i++) begin
      int v;
      int max;
      bit hit;
      max = p_max[i];
      v = lv % p_mod[i];
      m_tc[i] = 0;
      if (!r) begin
        m_cnt[i] = 0; m_dc[i] = 0; m_ovf[i] = 0;
      end else if (c) begin
        m_cnt[i] = 0; m_dc[i] = 0; m_ovf[i] = 0;
      end else if (l) begin
        m_cnt[i] = (v > max) ? max : v;
        m_dc[i] = 0;
      end else if (e) begin
        m_dc[i]++;
        if (m_dc[i] == p_div[i]) begin
          m_dc[i] = 0;
          hit = d ? (m_cnt[i] == max) : (m_cnt[i] == 0);
          if (hit) begin
            m_tc[i] = 1;
            m_ovf[i] = 1;
            if (!s) m_cnt[i] = d ? 0 : max;
          end else begin
            m_cnt[i] = d ? m_cnt[i] + 1 : m_cnt[i] - 1;
          end
        end
      end
    end
  endtask

  // apply one cycle of inputs at the falling edge and queue the post-edge expectation
  task automatic drive(input bit r, e, d, s, c, l, input int lv);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; dir = d; sat = s; clr = c; load = l; load_val = lv[7:0];
    model(r, e, d, s, c, l, lv);
    for (int i = 0; i < 3; i++) begin
      x.cnt[i] = 8'(m_cnt[i]);
      x.tc[i]  = m_tc[i][0];
      x.ovf[i] = m_ovf[i][0];
    end
    sbq.push_back(x);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // monitor: outputs are valid every cycle; compare just after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("count[%0d]", i), int'(act_cnt[i]), int'(e.cnt[i]));
          chk($sformatf("zero[%0d]", i), int'(act_zero[i]), int'(e.cnt[i] == 8'd0));
          chk($sformatf("tc[%0d]", i), int'(act_tc[i]), int'(e.tc[i]));
          chk($sformatf("ovf[%0d]", i), int'(act_ovf[i]), int'(e.ovf[i]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    chk("reset_count", int'(cnt_a), 0);
    chk("reset_zero", int'(zero_a), 1);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0);

    // decade wrap from reset
    repeat (12) drive(1, 1, 1, 0, 0, 0, 0);
    settle();
    chk("decade_a", int'(cnt_a), 2);
    chk("decade_ovf", int'(ovf_a), 1);
    chk("decade_b", int'(cnt_b), 4);
    chk("decade_c", int'(cnt_c), 12);

    // down wrap, then down saturate
    drive(1, 1, 0, 0, 0, 1, 2);
    repeat (3) drive(1, 1, 0, 0, 0, 0, 0);
    settle();
    chk("downwrap_cnt", int'(cnt_a), 9);
    chk("downwrap_tc", int'(tc_a), 1);
    drive(1, 1, 0, 1, 0, 1, 1);
    repeat (3) drive(1, 1, 0, 1, 0, 0, 0);
    settle();
    chk("downsat_cnt", int'(cnt_a), 0);
    chk("downsat_tc", int'(tc_a), 1);

    // prescaler with a two-cycle enable gap
    drive(1, 0, 1, 0, 1, 0, 0);
    repeat (4) drive(1, 1, 1, 0, 0, 0, 0);
    repeat (2) drive(1, 0, 1, 0, 0, 0, 0);
    repeat (5) drive(1, 1, 1, 0, 0, 0, 0);
    settle();
    chk("prescale_b", int'(cnt_b), 3);

    // priority: clr over load, load clamp, load over pending step
    drive(1, 1, 1, 0, 1, 1, 5);
    settle();
    chk("clr_wins_cnt", int'(cnt_a), 0);
    chk("clr_wins_ovf", int'(ovf_a), 0);
    drive(1, 0, 1, 0, 0, 1, 15);
    settle();
    chk("load_clamp", int'(cnt_a), 9);
    drive(1, 0, 1, 0, 1, 0, 0);
    repeat (2) drive(1, 1, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 1, 4);
    settle();
    chk("load_beats_step_b", int'(cnt_b), 4);
    chk("load_beats_step_a", int'(cnt_a), 4);

    // asynchronous reset between edges
    drive(1, 0, 1, 0, 0, 1, 9);
    drive(1, 1, 1, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 1, 7);
    settle();
    chk("pre_reset_cnt", int'(cnt_a), 7);
    chk("pre_reset_ovf", int'(ovf_a), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_cnt", int'(cnt_a), 0);
    chk("async_zero", int'(zero_a), 1);
    chk("async_tc", int'(tc_a), 0);
    chk("async_ovf", int'(ovf_a), 0);
    chk("async_cnt_c", int'(cnt_c), 0);
    model_reset();
    drive(0, 1, 1, 0, 0, 0, 0);
    repeat (3) drive(1, 1, 1, 0, 0, 0, 0);
    settle();
    chk("post_reset_b", int'(cnt_b), 1);
    chk("post_reset_a", int'(cnt_a), 3);

    // full-width wrap and saturate
    drive(1, 0, 1, 0, 0, 1, 254);
    repeat (2) drive(1, 1, 1, 0, 0, 0, 0);
    settle();
    chk("fullwrap_cnt", int'(cnt_c), 0);
    chk("fullwrap_tc", int'(tc_c), 1);
    drive(1, 0, 1, 1, 0, 1, 254);
    repeat (2) drive(1, 1, 1, 1, 0, 0, 0);
    settle();
    chk("fullsat_cnt", int'(cnt_c), 255);
    chk("fullsat_tc", int'(tc_c), 1);
    chk("fullsat_ovf", int'(ovf_c), 1);

    // randomized traffic
    repeat (400) begin
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
            1'($urandom), $urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0,
            int'($urandom_range(0, 255)));
    end

    repeat (3) @(posedge clk);
    #3;
    chk("drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
